// File: rtl/counter_step_scheduler.sv
// counter_step_scheduler: round-robin scheduler that hands out N-step en/mode bursts to requesters and checks the counter's end value.
//   clk, rst              : clock, synchronous active-high reset
//   req, req_mode, req_len: per-requester request level, direction (1 = up) and burst length
//   count_out             : counter value fed back from the datapath
//   en, mode              : counter enable and direction
//   gnt, done             : one-hot grant while running, one-cycle completion pulse
//   busy, err             : scheduler active, sticky end-of-burst mismatch
//   mismatch_cnt          : saturating count of end-of-burst mismatches
module counter_step_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [WIDTH-1:0]         count_out,
    output logic                     en,
    output logic                     mode,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     err,
    output logic [7:0]               mismatch_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n, id, id_n, win;
    logic               found, mode_l, mode_l_n, err_n;
    logic [LEN_W-1:0]   rem, rem_n, len_l, len_n;
    logic [WIDTH-1:0]   start, start_n, expected;
    logic [7:0]         cnt_n;
    logic [NUM_REQ-1:0] sel_n;
    int                 idx;

    // first requesting index at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign expected = mode_l ? start + WIDTH'(len_l) : start - WIDTH'(len_l);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        id_n     = id;
        mode_l_n = mode_l;
        rem_n    = rem;
        len_n    = len_l;
        start_n  = start;
        err_n    = err;
        cnt_n    = mismatch_cnt;
        case (state)
            IDLE: if (found) begin
                id_n     = win;
                mode_l_n = req_mode[win];
                rem_n    = req_len[int'(win)*LEN_W +: LEN_W];
                len_n    = req_len[int'(win)*LEN_W +: LEN_W];
                start_n  = count_out;
                ptr_n    = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_n  = (rem_n == '0) ? DONE : RUN;
            end
            RUN: begin
                rem_n   = rem - 1'b1;
                state_n = (rem == LEN_W'(1)) ? DONE : RUN;
            end
            DONE: begin
                state_n = IDLE;
                if (count_out != expected) begin
                    err_n = 1'b1;
                    cnt_n = (mismatch_cnt == 8'hFF) ? mismatch_cnt : mismatch_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        sel_n = NUM_REQ'(1) << id_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            id           <= '0;
            mode_l       <= 1'b0;
            rem          <= '0;
            len_l        <= '0;
            start        <= '0;
            en           <= 1'b0;
            mode         <= 1'b0;
            gnt          <= '0;
            done         <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            id           <= id_n;
            mode_l       <= mode_l_n;
            rem          <= rem_n;
            len_l        <= len_n;
            start        <= start_n;
            en           <= state_n == RUN;
            mode         <= state_n == RUN && mode_l_n;
            gnt          <= (state_n == RUN) ? sel_n : '0;
            done         <= (state_n == DONE) ? sel_n : '0;
            busy         <= state_n != IDLE;
            err          <= err_n;
            mismatch_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_counter_step_scheduler.sv
// tb_counter_step_scheduler: scenario tasks plus a randomized round-robin run checked against an arithmetic model.
module tb_counter_step_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int LEN_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ-1:0]       req_mode = '0;
    logic [NUM_REQ*LEN_W-1:0] req_len = '0;
    logic [WIDTH-1:0]         count_out = '0;
    logic                     en, mode, busy, err;
    logic [NUM_REQ-1:0]       gnt, done;
    logic [7:0]               mismatch_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic             freeze = 1'b0;
    int               ld_req = 0;
    int               ld_ack = 0;
    logic [WIDTH-1:0] ld_val = '0;

    counter_step_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_len(req_len),
        .count_out(count_out), .en(en), .mode(mode), .gnt(gnt), .done(done),
        .busy(busy), .err(err), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    // counter datapath; freeze models a stuck counter
    always @(posedge clk) begin
        if (ld_req != ld_ack) begin
            count_out <= ld_val;
            ld_ack    <= ld_req;
        end else if (en && !freeze) begin
            count_out <= mode ? count_out + 1'b1 : count_out - 1'b1;
        end
    end

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        if (v == '0) return -1;
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -2;
    endfunction

    task automatic load_count(input logic [WIDTH-1:0] v);
        ld_val = v;
        ld_req++;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // watches one burst up to its done pulse; gid/md go negative on inconsistent grant/direction
    task automatic observe(output int gid, output int did, output int ens, output int idle,
                           output int tot, output int md, output logic [WIDTH-1:0] cend, output bit to);
        gid = -1; did = -1; ens = 0; idle = 0; tot = 0; md = -1; cend = '0; to = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) idle++;
            else begin
                tot++;
                if (en) begin
                    ens++;
                    gid = (gid == -1 || gid == oh_idx(gnt)) ? oh_idx(gnt) : -3;
                    md  = (md == -1 || md == int'(mode)) ? int'(mode) : -3;
                end else if (gnt != '0) gid = -4;
                if (done != '0) begin
                    did  = oh_idx(done);
                    cend = count_out;
                    to   = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if ({en, mode, busy, err} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {en, mode, busy, err}); end
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        tests_run++; if (done !== '0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (mismatch_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", mismatch_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_burst;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        load_count(8'd0);
        @(negedge clk);
        req_len = '0; req_len[3:0] = 4'd3; req_mode = 4'b0001; req = 4'b0001;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        tests_run++; if (to) begin tests_failed++; $display("FAIL up_timeout: got no done expected done"); end
        tests_run++; if (d !== 0 || g !== 0) begin tests_failed++; $display("FAIL up_ids: got gnt %0d done %0d expected 0 0", g, d); end
        tests_run++; if (e !== 3 || t !== 4) begin tests_failed++; $display("FAIL up_timing: got en %0d done_at %0d expected 3 4", e, t); end
        tests_run++; if (m !== 1) begin tests_failed++; $display("FAIL up_mode: got %0d expected 1", m); end
        tests_run++; if (c !== 8'd3) begin tests_failed++; $display("FAIL up_count: got %0d expected 3", c); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL up_err: got %b expected 0", err); end
    endtask

    task automatic test_down_wrap;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        load_count(8'd0);
        @(negedge clk);
        req_len = '0; req_len[7:4] = 4'd2; req_mode = 4'b0000; req = 4'b0010;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        tests_run++; if (to || d !== 1 || e !== 2 || m !== 0) begin tests_failed++; $display("FAIL down_burst: got to %0d done %0d en %0d mode %0d expected 0 1 2 0", to, d, e, m); end
        tests_run++; if (c !== 8'd254) begin tests_failed++; $display("FAIL down_count: got %0d expected 254", c); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0 || mismatch_cnt !== 8'd0) begin tests_failed++; $display("FAIL down_err: got err %b cnt %0d expected 0 0", err, mismatch_cnt); end
    endtask

    task automatic test_round_robin;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        int ord [4];
        for (int p = 0; p < 2; p++) begin
            pulse_reset;
            req_mode = '1; req_len = {NUM_REQ{4'd1}};
            req = (p == 0) ? 4'b0101 : 4'b1101;
            ord = (p == 0) ? '{0, 2, 0, 2} : '{0, 2, 3, 0};
            for (int k = 0; k < 4; k++) begin
                observe(g, d, e, i, t, m, c, to);
                if (k == 3) req = '0;
                tests_run++; if (to || d !== ord[k] || g !== ord[k] || e !== 1) begin tests_failed++; $display("FAIL rr_order[%0d.%0d]: got done %0d gnt %0d en %0d expected %0d %0d 1", p, k, d, g, e, ord[k], ord[k]); end
                if (k > 0) begin
                    tests_run++; if (i !== 1) begin tests_failed++; $display("FAIL rr_gap[%0d.%0d]: got idle %0d expected 1", p, k, i); end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_len;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        req_len = '0; req_mode = '0; req = 4'b1000;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        tests_run++; if (to || d !== 3) begin tests_failed++; $display("FAIL zero_done: got %0d expected 3", d); end
        tests_run++; if (e !== 0 || g !== -1) begin tests_failed++; $display("FAIL zero_en: got en %0d gnt %0d expected 0 -1", e, g); end
        tests_run++; if (t !== 1 || i !== 0) begin tests_failed++; $display("FAIL zero_timing: got done_at %0d idle %0d expected 1 0", t, i); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL zero_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid;
        int g, d, e, i, t, m, n; logic [WIDTH-1:0] c; bit to;
        req_len = '0; req_len[3:0] = 4'd5; req_mode = 4'b0001; req = 4'b0001;
        n = 0;
        while (en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tests_run++; if (en !== 1'b1) begin tests_failed++; $display("FAIL rstmid_start: got en %b expected 1", en); end
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        tests_run++; if ({en, busy} !== 2'b00) begin tests_failed++; $display("FAIL rstmid_flags: got en %b busy %b expected 0 0", en, busy); end
        tests_run++; if (gnt !== '0 || done !== '0) begin tests_failed++; $display("FAIL rstmid_gnt_done: got %b %b expected 0 0", gnt, done); end
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (done !== '0) begin tests_failed++; $display("FAIL rstmid_nodone: got %b expected 0", done); end
        req_mode = '1; req_len = {NUM_REQ{4'd1}}; req = 4'b1111;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        tests_run++; if (to || d !== 0) begin tests_failed++; $display("FAIL rstmid_ptr: got first winner %0d expected 0", d); end
        @(negedge clk);
    endtask

    task automatic test_mismatch;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        pulse_reset;
        load_count(8'd10);
        @(negedge clk);
        freeze = 1'b1;
        req_len = '0; req_len[3:0] = 4'd4; req_mode = 4'b0001; req = 4'b0001;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        freeze = 1'b0;
        tests_run++; if (to || d !== 0 || e !== 4 || c !== 8'd10) begin tests_failed++; $display("FAIL mm_burst: got done %0d en %0d count %0d expected 0 4 10", d, e, c); end
        @(negedge clk);
        tests_run++; if (err !== 1'b1 || mismatch_cnt !== 8'd1) begin tests_failed++; $display("FAIL mm_flag: got err %b cnt %0d expected 1 1", err, mismatch_cnt); end
        req_len = '0; req_len[7:4] = 4'd2; req_mode = 4'b0000; req = 4'b0010;
        observe(g, d, e, i, t, m, c, to);
        req = '0;
        tests_run++; if (to || d !== 1 || c !== 8'd8) begin tests_failed++; $display("FAIL mm_clean: got done %0d count %0d expected 1 8", d, c); end
        @(negedge clk);
        tests_run++; if (err !== 1'b1 || mismatch_cnt !== 8'd1) begin tests_failed++; $display("FAIL mm_sticky: got err %b cnt %0d expected 1 1", err, mismatch_cnt); end
        pulse_reset;
        tests_run++; if (err !== 1'b0 || mismatch_cnt !== 8'd0) begin tests_failed++; $display("FAIL mm_clear: got err %b cnt %0d expected 0 0", err, mismatch_cnt); end
    endtask

    task automatic test_random;
        int g, d, e, i, t, m; logic [WIDTH-1:0] c; bit to;
        int ptr, w, ln, mcount, md_e;
        logic [NUM_REQ-1:0] rq, rm;
        logic [NUM_REQ*LEN_W-1:0] rl;
        pulse_reset;
        ptr = 0;
        for (int r = 0; r < 8; r++) begin
            rq = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            rm = NUM_REQ'($urandom);
            rl = (NUM_REQ*LEN_W)'($urandom);
            mcount = int'($urandom_range(0, 255));
            load_count(WIDTH'(mcount));
            @(negedge clk);
            req = rq; req_mode = rm; req_len = rl;
            for (int j = 0; j < 5; j++) begin
                w = -1;
                for (int k = 0; k < NUM_REQ && w < 0; k++)
                    if (rq[(ptr + k) % NUM_REQ]) w = (ptr + k) % NUM_REQ;
                ptr = (w + 1) % NUM_REQ;
                ln = int'(rl[w*LEN_W +: LEN_W]);
                md_e = int'(rm[w]);
                mcount = md_e == 1 ? (mcount + ln) % 256 : (mcount - ln + 256) % 256;
                observe(g, d, e, i, t, m, c, to);
                if (j == 4) req = '0;
                tests_run++; if (to || d !== w) begin tests_failed++; $display("FAIL rand_winner[%0d.%0d]: got %0d expected %0d", r, j, d, w); end
                tests_run++; if (e !== ln || g !== (ln > 0 ? w : -1)) begin tests_failed++; $display("FAIL rand_en[%0d.%0d]: got en %0d gnt %0d expected %0d %0d", r, j, e, g, ln, ln > 0 ? w : -1); end
                tests_run++; if (m !== (ln > 0 ? md_e : -1)) begin tests_failed++; $display("FAIL rand_mode[%0d.%0d]: got %0d expected %0d", r, j, m, ln > 0 ? md_e : -1); end
                tests_run++; if (c !== WIDTH'(mcount)) begin tests_failed++; $display("FAIL rand_count[%0d.%0d]: got %0d expected %0d", r, j, c, mcount); end
                if (j > 0) begin
                    tests_run++; if (i !== 1) begin tests_failed++; $display("FAIL rand_gap[%0d.%0d]: got idle %0d expected 1", r, j, i); end
                end
            end
        end
        @(negedge clk);
        tests_run++; if (err !== 1'b0 || mismatch_cnt !== 8'd0) begin tests_failed++; $display("FAIL rand_err: got err %b cnt %0d expected 0 0", err, mismatch_cnt); end
    endtask

    initial begin
        test_reset;
        test_up_burst;
        test_down_wrap;
        test_round_robin;
        test_zero_len;
        test_reset_mid;
        test_mismatch;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
